// File: rtl/guarded_sized_fifo_pkg.sv
// Shared helpers for guarded_sized_fifo: pointer wrap arithmetic and
// pointer-width sizing.
package guarded_sized_fifo_pkg;

    // Advance a pointer by one, wrapping from depth-1 back to 0.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                                 input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    // Smallest pointer width able to address depth entries (at least 1 bit).
    function automatic int unsigned min_ptr_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/guarded_fifo_mem.sv
// Storage array for guarded_sized_fifo: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module guarded_fifo_mem #(
    parameter int width      = 32,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [width-1:0]      rdata
);

    logic [width-1:0] mem [depth];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational from the registered read pointer and storage.
    assign rdata = mem[raddr];

endmodule

// File: rtl/guarded_sized_fifo.sv
// guarded_sized_fifo: parameterised single-clock FIFO with registered
// active-low FULL_N/EMPTY_N flags and a synchronous clear.
// Optional macro GUARDED_FIFO_CHECK_EN compiles in simulation-only messages
// for masked ENQ/DEQ (when guarded=1) and an elaboration check that
// p3cntr_width can address p2depth entries. Synthesised logic is the same.
module guarded_sized_fifo
    import guarded_sized_fifo_pkg::*;
#(
    parameter int p1width      = 32,
    parameter int p2depth      = 8,
    parameter int p3cntr_width = 3,
    parameter bit guarded      = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [p1width-1:0] D_IN,
    input  logic               ENQ,
    input  logic               DEQ,
    input  logic               CLR,
    output logic [p1width-1:0] D_OUT,
    output logic               FULL_N,
    output logic               EMPTY_N
);

    logic [p3cntr_width-1:0] rptr_reg, rptr_next, rptr_inc;
    logic [p3cntr_width-1:0] wptr_reg, wptr_next, wptr_inc;
    logic                    full_reg, full_next;
    logic                    empty_reg, empty_next;
    logic                    enq_fire, deq_fire;

    assign rptr_inc = p3cntr_width'(ptr_wrap_inc(32'(rptr_reg), p2depth));
    assign wptr_inc = p3cntr_width'(ptr_wrap_inc(32'(wptr_reg), p2depth));

    // Illegal operations are masked in both modes so state stays coherent
    // even if an unguarded caller breaks its contract.
    if (guarded) begin : g_guarded
        assign enq_fire = ENQ && !full_reg;
        assign deq_fire = DEQ && !empty_reg;
    end else begin : g_unguarded
        assign enq_fire = ENQ && !full_reg;
        assign deq_fire = DEQ && !empty_reg;
    end

    // Next pointers and flags; clear wins over enqueue/dequeue.
    always_comb begin
        rptr_next  = rptr_reg;
        wptr_next  = wptr_reg;
        full_next  = full_reg;
        empty_next = empty_reg;
        if (CLR) begin
            rptr_next  = '0;
            wptr_next  = '0;
            full_next  = 1'b0;
            empty_next = 1'b1;
        end else if (enq_fire && deq_fire) begin
            rptr_next = rptr_inc;
            wptr_next = wptr_inc;
        end else if (enq_fire) begin
            wptr_next  = wptr_inc;
            empty_next = 1'b0;
            full_next  = (wptr_inc == rptr_reg);
        end else if (deq_fire) begin
            rptr_next  = rptr_inc;
            full_next  = 1'b0;
            empty_next = (rptr_inc == wptr_reg);
        end
    end

    // Control state register; reset discards contents immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
        end
    end

    // Clear leaves storage untouched, so the write is suppressed with it.
    guarded_fifo_mem #(
        .width      (p1width),
        .depth      (p2depth),
        .addr_width (p3cntr_width)
    ) u_mem (
        .clk   (CLK),
        .we    (enq_fire && !CLR),
        .waddr (wptr_reg),
        .wdata (D_IN),
        .raddr (rptr_reg),
        .rdata (D_OUT)
    );

    assign FULL_N  = !full_reg;
    assign EMPTY_N = !empty_reg;

`ifdef GUARDED_FIFO_CHECK_EN
    if (p3cntr_width < min_ptr_width(p2depth)) begin : g_width_check
        $error("guarded_sized_fifo: p3cntr_width too small for p2depth");
    end

    if (guarded) begin : g_op_checks
        // Report every masked operation with instance path and time.
        always @(posedge CLK) begin
            if (RST && !CLR && ENQ && full_reg) begin
                $display("%m @%0t: ENQ on full FIFO", $time);
            end
            if (RST && !CLR && DEQ && empty_reg) begin
                $display("%m @%0t: DEQ on empty FIFO", $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_guarded_sized_fifo.sv
// Directed self-checking bench for guarded_sized_fifo (8 x 32, guarded).
module tb_guarded_sized_fifo;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] D_IN = '0;
    logic        ENQ = 1'b0;
    logic        DEQ = 1'b0;
    logic        CLR = 1'b0;
    logic [31:0] D_OUT;
    logic        FULL_N;
    logic        EMPTY_N;

    int errors = 0;
    int checks = 0;

    guarded_sized_fifo #(
        .p1width      (32),
        .p2depth      (8),
        .p3cntr_width (3),
        .guarded      (1'b1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D_IN    (D_IN),
        .ENQ     (ENQ),
        .DEQ     (DEQ),
        .CLR     (CLR),
        .D_OUT   (D_OUT),
        .FULL_N  (FULL_N),
        .EMPTY_N (EMPTY_N)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given controls; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic enq, input logic deq, input logic clr, input logic [31:0] d);
        ENQ = enq; DEQ = deq; CLR = clr; D_IN = d;
        @(posedge CLK);
        #1;
        ENQ = 1'b0; DEQ = 1'b0; CLR = 1'b0;
        $display("cycle enq=%0b deq=%0b clr=%0b din=%h -> empty_n=%0b full_n=%0b dout=%h",
                 enq, deq, clr, d, EMPTY_N, FULL_N, D_OUT);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_empty_n", 32'(EMPTY_N), 32'd0);
        check("reset_full_n", 32'(FULL_N), 32'd1);
        RST = 1'b1;
        @(negedge CLK);

        // First enqueue visible after one edge
        cyc(1, 0, 0, 32'h11);
        check("first_empty_n", 32'(EMPTY_N), 32'd1);
        check("first_dout", D_OUT, 32'h11);
        cyc(0, 1, 0, 32'h0);
        check("first_drain_empty_n", 32'(EMPTY_N), 32'd0);

        // Fill to full; FULL_N drops only after the 8th
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 0, 32'(i));
            check("fill_full_n", 32'(FULL_N), (i == 8) ? 32'd0 : 32'd1);
        end
        check("fill_head", D_OUT, 32'h1);
        cyc(1, 0, 0, 32'h9);
        check("ovf_full_n", 32'(FULL_N), 32'd0);
        check("ovf_head", D_OUT, 32'h1);

        // Drain in order; 0x9 must not appear
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", D_OUT, 32'(i));
            cyc(0, 1, 0, 32'h0);
        end
        check("drain_empty_n", 32'(EMPTY_N), 32'd0);
        check("drain_full_n", 32'(FULL_N), 32'd1);
        cyc(0, 1, 0, 32'h0);
        check("udf_empty_n", 32'(EMPTY_N), 32'd0);

        // Occupancy 3 with 20 cycles of simultaneous ENQ+DEQ across wrap
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h100 + 32'(i));
        for (int k = 0; k < 20; k++) begin
            check("stream_head", D_OUT, 32'h100 + 32'(k));
            cyc(1, 1, 0, 32'h103 + 32'(k));
            check("stream_empty_n", 32'(EMPTY_N), 32'd1);
            check("stream_full_n", 32'(FULL_N), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            check("stream_tail", D_OUT, 32'h114 + 32'(k));
            cyc(0, 1, 0, 32'h0);
        end
        check("stream_occ_empty_n", 32'(EMPTY_N), 32'd0);

        // Full FIFO with ENQ+DEQ: dequeue only
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 32'hA0 + 32'(i));
        check("full2_full_n", 32'(FULL_N), 32'd0);
        cyc(1, 1, 0, 32'hEE);
        check("fullboth_full_n", 32'(FULL_N), 32'd1);
        check("fullboth_head", D_OUT, 32'hA1);
        for (int i = 1; i < 8; i++) begin
            check("fullboth_drain", D_OUT, 32'hA0 + 32'(i));
            cyc(0, 1, 0, 32'h0);
        end
        check("fullboth_empty_n", 32'(EMPTY_N), 32'd0);

        // Empty FIFO with ENQ+DEQ: enqueue only
        cyc(1, 1, 0, 32'h55);
        check("emptyboth_empty_n", 32'(EMPTY_N), 32'd1);
        check("emptyboth_head", D_OUT, 32'h55);
        cyc(0, 1, 0, 32'h0);
        check("emptyboth_drain", 32'(EMPTY_N), 32'd0);

        // CLR beats a concurrent ENQ
        for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 32'h60 + 32'(i));
        check("preclr_head", D_OUT, 32'h61);
        cyc(1, 0, 1, 32'h77);
        check("clr_empty_n", 32'(EMPTY_N), 32'd0);
        check("clr_full_n", 32'(FULL_N), 32'd1);
        cyc(1, 0, 0, 32'h88);
        check("postclr_head", D_OUT, 32'h88);
        cyc(0, 1, 0, 32'h0);
        check("postclr_empty_n", 32'(EMPTY_N), 32'd0);

        // Asynchronous reset between edges at occupancy 4
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'hC0 + 32'(i));
        check("prerst_empty_n", 32'(EMPTY_N), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_empty_n", 32'(EMPTY_N), 32'd0);
        check("async_rst_full_n", 32'(FULL_N), 32'd1);
        #2;
        RST = 1'b1;
        cyc(0, 0, 0, 32'h0);
        check("postrst_empty_n", 32'(EMPTY_N), 32'd0);
        cyc(1, 0, 0, 32'h99);
        check("postrst_head", D_OUT, 32'h99);
        check("postrst_empty_n2", 32'(EMPTY_N), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
